// File: rtl/program_loader.sv
// program_loader: assembles UART bytes big-endian into 32-bit words and writes them to instruction memory.
module program_loader #(
  parameter int          INST_MEM_ADDR_WIDTH = 9,
  parameter logic [31:0] HALT_WORD           = 32'hFFFFFFFF
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start_load,
  input  logic [7:0]                       i_rx_data,
  input  logic                             i_rx_valid,
  output logic                             o_write_instruction_flag,
  output logic [31:0]                      o_instruction_to_write,
  output logic [INST_MEM_ADDR_WIDTH-1:0]   o_address_to_write_inst,
  output logic                             o_loading,
  output logic                             o_load_done,
  output logic                             o_overflow,
  output logic [INST_MEM_ADDR_WIDTH-2:0]   o_word_count
);
  localparam int AW = INST_MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = {{(AW-2){1'b1}}, 2'b00};
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t          state_q, state_d;
  logic [23:0]     shreg_q;
  logic [1:0]      cnt_q;
  logic [31:0]     inst_q;
  logic [AW-1:0]   addr_q;
  logic [AW-2:0]   wc_q;
  logic            ovf_q;
  logic            restart, accept;
  assign restart = i_start_load && (state_q == IDLE || state_q == DONE);
  assign accept  = i_rx_valid && (state_q == RECV || state_q == WRITE);
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = i_start_load ? RECV : state_q;
      RECV:       state_d = (i_rx_valid && cnt_q == 2'd3) ? WRITE : RECV;
      WRITE:      state_d = (inst_q == HALT_WORD || addr_q == LAST_ADDR) ? DONE : RECV;
      default:    state_d = IDLE;
    endcase
  end
  // A byte arriving during WRITE is kept so back-to-back streams lose nothing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (restart) begin
        addr_q <= '0;
        cnt_q  <= '0;
        wc_q   <= '0;
        ovf_q  <= 1'b0;
      end
      if (accept) begin
        shreg_q <= {shreg_q[15:0], i_rx_data};
        cnt_q   <= cnt_q + 2'd1;
        if (state_q == RECV && cnt_q == 2'd3) inst_q <= {shreg_q, i_rx_data};
      end
      if (state_q == WRITE) begin
        wc_q <= wc_q + (AW-1)'(1);
        if (inst_q != HALT_WORD && addr_q == LAST_ADDR) ovf_q <= 1'b1;
        if (state_d == RECV) addr_q <= addr_q + AW'(4);
      end
    end
  end
  always_comb begin
    o_write_instruction_flag = state_q == WRITE;
    o_loading                = state_q == RECV || state_q == WRITE;
    o_load_done              = state_q == DONE;
    o_overflow               = ovf_q;
    o_instruction_to_write   = inst_q;
    o_address_to_write_inst  = addr_q;
    o_word_count             = wc_q;
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vector table plus overflow sequence for program_loader.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [7:0]  data;
  logic        we, loading, done, ovf;
  logic [31:0] inst;
  logic [8:0]  addr;
  logic [7:0]  wc;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  program_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start_load(start), .i_rx_data(data), .i_rx_valid(valid),
    .o_write_instruction_flag(we), .o_instruction_to_write(inst), .o_address_to_write_inst(addr),
    .o_loading(loading), .o_load_done(done), .o_overflow(ovf), .o_word_count(wc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, st, vl;
    logic [7:0]  d;
    logic        we;
    logic [31:0] ins;
    logic [8:0]  a;
    logic        ld, dn, ov;
    logic [7:0]  wc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic w, logic [31:0] i,
                              logic [8:0] a, logic l, logic dn, logic o, logic [7:0] c);
    return {r, s, v, d, w, i, a, l, dn, o, c};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(logic r, logic s, logic v, logic [7:0] d);
    rst = r; start = s; valid = v; data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; valid = 1'b0; data = 8'h00;
  endtask

  function automatic logic [52:0] outs();
    return {we, inst, addr, loading, done, ovf, wc};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00;
    // rst st vl data | we inst addr loading done ovf wc
    vecs.push_back(mk(1,0,0,8'h00, 0,32'h0,       9'd0, 0,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h5A, 0,32'h0,       9'd0, 0,0,0,8'd0));
    vecs.push_back(mk(0,1,0,8'h00, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h20, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h08, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h00, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h05, 1,32'h20080005,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,0,8'h00, 0,32'h20080005,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h11, 0,32'h20080005,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h22, 0,32'h20080005,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h33, 0,32'h20080005,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h44, 1,32'h11223344,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'hAA, 0,32'h11223344,9'd8, 1,0,0,8'd2));
    vecs.push_back(mk(0,0,1,8'hBB, 0,32'h11223344,9'd8, 1,0,0,8'd2));
    vecs.push_back(mk(0,0,1,8'hCC, 0,32'h11223344,9'd8, 1,0,0,8'd2));
    vecs.push_back(mk(0,0,1,8'hDD, 1,32'hAABBCCDD,9'd8, 1,0,0,8'd2));
    vecs.push_back(mk(0,0,0,8'h00, 0,32'hAABBCCDD,9'd12,1,0,0,8'd3));
    vecs.push_back(mk(0,0,1,8'hFF, 0,32'hAABBCCDD,9'd12,1,0,0,8'd3));
    vecs.push_back(mk(0,0,1,8'hFF, 0,32'hAABBCCDD,9'd12,1,0,0,8'd3));
    vecs.push_back(mk(0,0,1,8'hFF, 0,32'hAABBCCDD,9'd12,1,0,0,8'd3));
    vecs.push_back(mk(0,0,1,8'hFF, 1,32'hFFFFFFFF,9'd12,1,0,0,8'd3));
    vecs.push_back(mk(0,0,0,8'h00, 0,32'hFFFFFFFF,9'd12,0,1,0,8'd4));
    vecs.push_back(mk(0,0,1,8'h12, 0,32'hFFFFFFFF,9'd12,0,1,0,8'd4));
    vecs.push_back(mk(0,1,0,8'h00, 0,32'hFFFFFFFF,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h01, 0,32'hFFFFFFFF,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,1,0,8'h00, 0,32'hFFFFFFFF,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h02, 0,32'hFFFFFFFF,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h03, 0,32'hFFFFFFFF,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h04, 1,32'h01020304,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,0,8'h00, 0,32'h01020304,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h55, 0,32'h01020304,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(0,0,1,8'h66, 0,32'h01020304,9'd4, 1,0,0,8'd1));
    vecs.push_back(mk(1,0,1,8'h77, 0,32'h0,       9'd0, 0,0,0,8'd0));
    vecs.push_back(mk(0,1,0,8'h00, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h77, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h88, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'h99, 0,32'h0,       9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,1,8'hAA, 1,32'h778899AA,9'd0, 1,0,0,8'd0));
    vecs.push_back(mk(0,0,0,8'h00, 0,32'h778899AA,9'd4, 1,0,0,8'd1));
    step(1, 0, 0, 8'h00);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].vl, vecs[i].d);
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].we, vecs[i].ins, vecs[i].a, vecs[i].ld, vecs[i].dn, vecs[i].ov, vecs[i].wc}));
    end
    // Fill all 128 words with non-HALT data, bytes streamed back to back.
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int k = 0; k < 128; k++) begin
      logic [31:0] w;
      w = {8'hA5, 8'h00, 8'h01, 8'(k)};
      for (int b = 3; b >= 0; b--) step(0, 0, 1, w[b*8 +: 8]);
      chk($sformatf("fill%0d", k), {31'h0, we, inst}, {31'h0, 1'b1, w});
      chk($sformatf("fill_addr%0d", k), 64'(addr), 64'(k * 4));
    end
    step(0, 0, 0, 8'h00);
    chk("ovf_state", 64'({loading, done, ovf, wc, addr}), 64'({1'b0, 1'b1, 1'b1, 8'd128, 9'd508}));
    begin
      int writes = 0;
      for (int b = 0; b < 6; b++) begin
        step(0, 0, 1, 8'h3C);
        writes += int'(we);
      end
      chk("ovf_no_write", 64'(writes), 64'd0);
    end
    chk("ovf_sticky", 64'({done, ovf, wc}), 64'({1'b1, 1'b1, 8'd128}));
    step(0, 1, 0, 8'h00);
    chk("ovf_restart", 64'({loading, done, ovf, wc, addr}), 64'({1'b1, 1'b0, 1'b0, 8'd0, 9'd0}));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the instruction-fetch stage's write port.
- Receives program bytes from the UART RX byte stream and assembles them big-endian into 32-bit instructions.
- Writes each instruction into instruction memory at consecutive word addresses, and holds the pipeline halted while loading.
- Loading ends on a HALT instruction word or when memory is full.

Parameters:
- INST_MEM_ADDR_WIDTH, 9, byte-address width of instruction memory (2^9 = 512 bytes = 128 words).
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates a load; it is itself written to memory.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start_load  in  1  one-cycle pulse; starts a new load from address 0.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle.
- o_write_instruction_flag  out  1  instruction-memory write enable, one cycle per word.
- o_instruction_to_write  out  32  assembled instruction.
- o_address_to_write_inst  out  INST_MEM_ADDR_WIDTH  byte address of the write.
- o_loading  out  1  high while a load is in progress; drives the pipeline halt.
- o_load_done  out  1  high once a load has completed; sticky.
- o_overflow  out  1  load ended because memory filled without HALT_WORD; sticky.
- o_word_count  out  INST_MEM_ADDR_WIDTH-1  number of words written in the current/last load.

Behaviour:
- Reset (also mid-operation): state IDLE. All outputs 0, byte counter 0, shift register 0.
- State IDLE:
  - i_start_load=1 -> RECV; clear address, byte counter, word count, o_load_done, o_overflow.
  - i_rx_valid is ignored.
- State RECV:
  - o_loading=1.
  - Each i_rx_valid shifts in: shreg <= {shreg[23:0], i_rx_data}; byte counter increments.
  - On the 4th byte: latch {shreg[23:0], i_rx_data} into o_instruction_to_write, reset byte counter to 0, go to WRITE.
  - i_start_load is ignored.
- State WRITE (exactly 1 cycle):
  - o_write_instruction_flag=1 and o_loading=1; o_address_to_write_inst holds the current address.
  - An i_rx_valid this cycle is still accepted into shreg/byte counter, so no byte is lost.
  - o_word_count increments at the end of the cycle.
  - Next state, by priority:
    - (a) word == HALT_WORD -> DONE.
    - (b) address == 2^INST_MEM_ADDR_WIDTH - 4 -> DONE and set o_overflow=1.
    - (c) otherwise address += 4 -> RECV.
- State DONE:
  - o_load_done=1, o_loading=0, write enable 0; bytes are ignored.
  - i_start_load -> same restart as in IDLE.
- Timing and widths:
  - Write enable is registered; latency from the 4th byte strobe to write enable is 1 cycle.
  - o_instruction_to_write and o_address_to_write_inst hold their last values outside WRITE.
  - Address is always word-aligned (bits [1:0]=0) and never wraps.
  - A partial word (1-3 bytes) left when reset or DONE occurs is discarded and never written.

Test Plan:
- Reset, start, bytes 20,08,00,05 -> 1 cycle after the 4th byte: write enable=1, data=32'h20080005, addr=0. Next cycle: state RECV, o_loading=1, o_word_count=1.
- Load 3 words, then bytes FF,FF,FF,FF -> 4 write pulses at addrs 0,4,8,12, the last with data FFFFFFFF. Then o_load_done=1, o_loading=0, o_overflow=0, o_word_count=4.
- Stream 128 non-HALT words -> last write at addr 508. Then o_load_done=1, o_overflow=1, o_word_count=128; further bytes produce no writes.
- Byte strobe in the same cycle as WRITE -> that byte becomes MSB of the next word; the following word writes correctly at addr+4.
- Reset asserted after 2 bytes of word 2 -> all outputs 0 next cycle. A new start plus 4 bytes writes at addr 0 with no stale bytes.
- From DONE, i_start_load -> o_load_done=0, address 0; i_start_load pulsed during RECV -> no effect on address or count.
